pipe_ctrl: RTL and testbench

Central hazard and sequencing controller for the five-stage pipeline. Drives the `en` and `flush` inputs of the PC register and the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers. Resolves:
- load-use stalls,
- taken jump/branch flushes,
- multi-cycle data-memory waits, with a timeout,
- halt/resume on `ecall`.

Outputs are decoded combinationally from the registered state and the current inputs. The state machine and wait counter are registered.

---
 rtl/pipe_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and sequencing controller driving the five-stage pipeline register enables/flushes.
// Optional stall/flush performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd_addr,
  input  logic       ex_jump,
  input  logic       mem_req,
  input  logic       mem_ready,
  input  logic       halt_req,
  input  logic       resume,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       id_ex_en,
  output logic       ex_mem_en,
  output logic       mem_wb_en,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       ex_mem_flush,
  output logic       mem_wb_flush,
  output logic       halted,
  output logic       mem_err
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int WCNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, HALT = 2'd2} state_t;

  state_t            state, state_nx;
  logic [WCNT_W-1:0] wcnt, wcnt_nx;
  logic              err_nx;
  logic              active, mem_stall, load_use;
  logic              rule_halt, rule_mem, rule_jump, rule_lu;

  if (TIMEOUT < 2 || CNT_W < 1) begin : g_bad_param
    $error("pipe_ctrl: TIMEOUT must be >= 2 and CNT_W >= 1");
  end

  assign active    = (state != HALT);
  assign mem_stall = mem_req & ~mem_ready;
  assign load_use  = ex_mem_read & (ex_rd_addr != 5'd0) &
                     ((id_rs1_used & (id_rs1_addr == ex_rd_addr)) |
                      (id_rs2_used & (id_rs2_addr == ex_rd_addr)));

  // Hazard priority: halt, memory wait, jump, load-use
  assign rule_halt = active & halt_req;
  assign rule_mem  = active & ~halt_req & mem_stall;
  assign rule_jump = active & ~halt_req & ~mem_stall & ex_jump;
  assign rule_lu   = active & ~halt_req & ~mem_stall & ~ex_jump & load_use;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      wcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      state   <= state_nx;
      wcnt    <= wcnt_nx;
      mem_err <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    err_nx   = mem_err;
    unique case (state)
      RUN: begin
        if (halt_req) begin
          state_nx = HALT;
        end else if (mem_stall) begin
          state_nx = MEM_WAIT;
          wcnt_nx  = WCNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (halt_req) begin
          state_nx = HALT;
          wcnt_nx  = '0;
        end else if (mem_ready) begin
          state_nx = RUN;
          wcnt_nx  = '0;
        end else if (wcnt == WCNT_W'(TIMEOUT - 1)) begin
          state_nx = HALT;
          wcnt_nx  = '0;
          err_nx   = 1'b1;
        end else begin
          wcnt_nx = wcnt + WCNT_W'(1);
        end
      end
      HALT: begin
        if (resume) state_nx = RUN;
      end
      default: begin
        state_nx = RUN;
        wcnt_nx  = '0;
      end
    endcase
  end

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    if (!rst || !active) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (rule_halt) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (rule_mem) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (rule_jump) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (rule_lu) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  assign halted = (state == HALT);

`ifdef PIPE_CTRL_PERF_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (active && !pc_en) stall_cnt <= sat_inc(stall_cnt);
      if (rule_jump)        flush_cnt <= sat_inc(flush_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized bench for pipe_ctrl, two instances (TIMEOUT=16 and TIMEOUT=4)
// compared against a behavioural model of the hazard rules.
module tb_pipe_ctrl;

  localparam int M_RUN  = 0;
  localparam int M_WAIT = 1;
  localparam int M_HALT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic       id_rs1_used, id_rs2_used, ex_mem_read, ex_jump;
  logic       mem_req, mem_ready, halt_req, resume;

  logic [1:0] pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic [1:0] if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [1:0] halted, mem_err;
  logic [10:0] obs [2];
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt [2];
  logic [31:0] flush_cnt [2];
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_mode [2];
  int          m_wait [2];
  bit          m_err  [2];
  logic [31:0] m_stall [2];
  logic [31:0] m_flush [2];
  int          to_val [2] = '{16, 4};

  always #5 clk = ~clk;

  pipe_ctrl #(.TIMEOUT(16)) u_to16 (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr), .ex_jump(ex_jump),
    .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req), .resume(resume),
    .pc_en(pc_en[0]), .if_id_en(if_id_en[0]), .id_ex_en(id_ex_en[0]),
    .ex_mem_en(ex_mem_en[0]), .mem_wb_en(mem_wb_en[0]),
    .if_id_flush(if_id_flush[0]), .id_ex_flush(id_ex_flush[0]),
    .ex_mem_flush(ex_mem_flush[0]), .mem_wb_flush(mem_wb_flush[0]),
    .halted(halted[0]), .mem_err(mem_err[0])
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt(stall_cnt[0]), .flush_cnt(flush_cnt[0])
`endif
  );

  pipe_ctrl #(.TIMEOUT(4)) u_to4 (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr), .ex_jump(ex_jump),
    .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req), .resume(resume),
    .pc_en(pc_en[1]), .if_id_en(if_id_en[1]), .id_ex_en(id_ex_en[1]),
    .ex_mem_en(ex_mem_en[1]), .mem_wb_en(mem_wb_en[1]),
    .if_id_flush(if_id_flush[1]), .id_ex_flush(id_ex_flush[1]),
    .ex_mem_flush(ex_mem_flush[1]), .mem_wb_flush(mem_wb_flush[1]),
    .halted(halted[1]), .mem_err(mem_err[1])
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt(stall_cnt[1]), .flush_cnt(flush_cnt[1])
`endif
  );

  for (genvar g = 0; g < 2; g++) begin : g_obs
    assign obs[g] = {pc_en[g], if_id_en[g], id_ex_en[g], ex_mem_en[g], mem_wb_en[g],
                     if_id_flush[g], id_ex_flush[g], ex_mem_flush[g], mem_wb_flush[g],
                     halted[g], mem_err[g]};
  end

  // Expected {en[4:0], flush[3:0], halted, mem_err} from the hazard rules
  function automatic logic [10:0] model_out(int k);
    logic [4:0] en;
    logic [3:0] fl;
    bit         lu;
    if (!rst) return 11'b0;
    en = 5'b11111;
    fl = 4'b0000;
    lu = ex_mem_read && (ex_rd_addr != 5'd0) &&
         ((id_rs1_used && id_rs1_addr == ex_rd_addr) || (id_rs2_used && id_rs2_addr == ex_rd_addr));
    if (m_mode[k] == M_HALT) en = 5'b00000;
    else if (halt_req) begin en = 5'b00000; fl = 4'b0001; end
    else if (mem_req && !mem_ready) begin en = 5'b00001; fl = 4'b0001; end
    else if (ex_jump) fl = 4'b1100;
    else if (lu) begin en = 5'b00111; fl = 4'b0100; end
    return {en, fl, (m_mode[k] == M_HALT), m_err[k]};
  endfunction

  task automatic tick();
    logic [10:0] e;
    for (int k = 0; k < 2; k++) begin
      e = model_out(k);
      if (!rst) begin
        m_mode[k] = M_RUN; m_wait[k] = 0; m_err[k] = 0; m_stall[k] = '0; m_flush[k] = '0;
      end else if (m_mode[k] == M_HALT) begin
        if (resume) m_mode[k] = M_RUN;
      end else begin
        if (!e[10] && m_stall[k] != '1) m_stall[k]++;
        if (!halt_req && !(mem_req && !mem_ready) && ex_jump && m_flush[k] != '1) m_flush[k]++;
        if (halt_req) begin
          m_mode[k] = M_HALT; m_wait[k] = 0;
        end else if (m_mode[k] == M_RUN) begin
          if (mem_req && !mem_ready) begin m_mode[k] = M_WAIT; m_wait[k] = 1; end
        end else if (mem_ready) begin
          m_mode[k] = M_RUN; m_wait[k] = 0;
        end else if (m_wait[k] + 1 == to_val[k]) begin
          m_mode[k] = M_HALT; m_wait[k] = 0; m_err[k] = 1;
        end else begin
          m_wait[k]++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1_addr = '0; id_rs2_addr = '0; ex_rd_addr = '0;
    id_rs1_used = 0; id_rs2_used = 0; ex_mem_read = 0; ex_jump = 0;
    mem_req = 0; mem_ready = 0; halt_req = 0; resume = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (obs[k] !== 11'b0) begin n_fail++; $display("FAIL reset_outputs dut%0d got=%b want=%b", k, obs[k], 11'b0); end
      end
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (obs[k] !== 11'b11111_0000_00) begin n_fail++; $display("FAIL first_run dut%0d got=%b want=%b", k, obs[k], 11'b11111_0000_00); end
    end
    tick();
  endtask

  task automatic test_load_use();
    ex_mem_read = 1; ex_rd_addr = 5'd5; id_rs2_addr = 5'd5; id_rs2_used = 1;
    id_rs1_addr = 5'd7; id_rs1_used = 1;
    @(negedge clk);
    n_tests++;
    if (obs[0] !== 11'b00111_0100_00) begin n_fail++; $display("FAIL load_use_stall got=%b want=%b", obs[0], 11'b00111_0100_00); end
    tick();
    ex_mem_read = 0; ex_rd_addr = 5'd0;
    @(negedge clk);
    n_tests++;
    if (obs[0] !== 11'b11111_0000_00) begin n_fail++; $display("FAIL load_use_one_bubble got=%b want=%b", obs[0], 11'b11111_0000_00); end
    tick();
    ex_mem_read = 1; ex_rd_addr = 5'd0; id_rs2_addr = 5'd0;
    @(negedge clk);
    n_tests++;
    if (obs[0] !== 11'b11111_0000_00) begin n_fail++; $display("FAIL load_use_x0 got=%b want=%b", obs[0], 11'b11111_0000_00); end
    tick();
    ex_rd_addr = 5'd9; id_rs1_addr = 5'd9; id_rs1_used = 0; id_rs2_addr = 5'd3;
    @(negedge clk);
    n_tests++;
    if (obs[0] !== 11'b11111_0000_00) begin n_fail++; $display("FAIL load_use_unused_src got=%b want=%b", obs[0], 11'b11111_0000_00); end
    tick();
    clear_inputs();
  endtask

  task automatic test_jump_load_use();
    logic [31:0] s0, f0;
    ex_mem_read = 1; ex_rd_addr = 5'd12; id_rs1_addr = 5'd12; id_rs1_used = 1; ex_jump = 1;
    s0 = m_stall[0];
    f0 = m_flush[0];
    @(negedge clk);
    n_tests++;
    if (obs[0] !== 11'b11111_1100_00) begin n_fail++; $display("FAIL jump_over_load_use got=%b want=%b", obs[0], 11'b11111_1100_00); end
    tick();
`ifdef PIPE_CTRL_PERF_EN
    n_tests++;
    if (flush_cnt[0] !== f0 + 32'd1 || stall_cnt[0] !== s0) begin
      n_fail++;
      $display("FAIL jump_counters got stall=%0d flush=%0d want stall=%0d flush=%0d", stall_cnt[0], flush_cnt[0], s0, f0 + 32'd1);
    end
`endif
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    mem_req = 1; mem_ready = 0;
    repeat (3) begin
      @(negedge clk);
      n_tests += 2;
      if (obs[0] !== 11'b00001_0001_00) begin n_fail++; $display("FAIL mem_wait_frozen got=%b want=%b", obs[0], 11'b00001_0001_00); end
      if (obs[1] !== model_out(1)) begin n_fail++; $display("FAIL mem_wait_to4 got=%b want=%b", obs[1], model_out(1)); end
      tick();
    end
    mem_ready = 1;
    @(negedge clk);
    n_tests++;
    if (obs[0] !== 11'b11111_0000_00) begin n_fail++; $display("FAIL mem_wait_ready got=%b want=%b", obs[0], 11'b11111_0000_00); end
    tick();
    clear_inputs();
    ex_jump = 1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (obs[k] !== 11'b11111_1100_00) begin n_fail++; $display("FAIL mem_wait_back_in_run dut%0d got=%b want=%b", k, obs[k], 11'b11111_1100_00); end
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_timeout();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      resume = (i == 3);
      @(negedge clk);
      n_tests++;
      if (obs[1] !== 11'b00001_0001_00) begin n_fail++; $display("FAIL timeout_wait cycle%0d got=%b want=%b", i, obs[1], 11'b00001_0001_00); end
      tick();
    end
    resume = 0;
    repeat (2) begin
      @(negedge clk);
      n_tests += 2;
      if (obs[1] !== 11'b00000_0000_11) begin n_fail++; $display("FAIL timeout_halt got=%b want=%b", obs[1], 11'b00000_0000_11); end
      if (obs[0] !== 11'b00001_0001_00) begin n_fail++; $display("FAIL timeout_to16_still_waiting got=%b want=%b", obs[0], 11'b00001_0001_00); end
      tick();
    end
    mem_ready = 1; resume = 1;
    @(negedge clk);
    n_tests++;
    if (obs[1] !== 11'b00000_0000_11) begin n_fail++; $display("FAIL timeout_resume_cycle got=%b want=%b", obs[1], 11'b00000_0000_11); end
    tick();
    clear_inputs();
    @(negedge clk);
    n_tests += 2;
    if (obs[1] !== 11'b11111_0000_01) begin n_fail++; $display("FAIL timeout_err_sticky got=%b want=%b", obs[1], 11'b11111_0000_01); end
    if (obs[0] !== 11'b11111_0000_00) begin n_fail++; $display("FAIL timeout_to16_run got=%b want=%b", obs[0], 11'b11111_0000_00); end
    tick();
  endtask

  task automatic test_halt();
    halt_req = 1;
    @(negedge clk);
    n_tests += 2;
    if (obs[0] !== 11'b00000_0001_00) begin n_fail++; $display("FAIL halt_entry got=%b want=%b", obs[0], 11'b00000_0001_00); end
    if (obs[1] !== model_out(1)) begin n_fail++; $display("FAIL halt_entry_to4 got=%b want=%b", obs[1], model_out(1)); end
    tick();
    halt_req = 0; ex_jump = 1; mem_req = 1;
    repeat (5) begin
      @(negedge clk);
      n_tests++;
      if (obs[0] !== 11'b00000_0000_10) begin n_fail++; $display("FAIL halt_frozen got=%b want=%b", obs[0], 11'b00000_0000_10); end
      tick();
    end
    resume = 1;
    @(negedge clk);
    n_tests++;
    if (obs[0] !== 11'b00000_0000_10) begin n_fail++; $display("FAIL halt_resume_cycle got=%b want=%b", obs[0], 11'b00000_0000_10); end
    tick();
    clear_inputs();
    @(negedge clk);
    n_tests += 2;
    if (obs[0] !== 11'b11111_0000_00) begin n_fail++; $display("FAIL halt_released got=%b want=%b", obs[0], 11'b11111_0000_00); end
    if (obs[1] !== 11'b11111_0000_01) begin n_fail++; $display("FAIL halt_released_to4 got=%b want=%b", obs[1], 11'b11111_0000_01); end
    tick();
  endtask

  task automatic test_async_reset();
    mem_req = 1; mem_ready = 0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (obs[k] !== 11'b0) begin n_fail++; $display("FAIL async_reset_outputs dut%0d got=%b want=%b", k, obs[k], 11'b0); end
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs[1] !== 11'b00001_0001_00) begin n_fail++; $display("FAIL post_reset_wait cycle%0d got=%b want=%b", i, obs[1], 11'b00001_0001_00); end
      tick();
    end
    @(negedge clk);
    n_tests++;
    if (obs[1] !== 11'b00000_0000_11) begin n_fail++; $display("FAIL post_reset_timeout got=%b want=%b", obs[1], 11'b00000_0000_11); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    clear_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 99) != 0);
      id_rs1_addr = 5'($urandom_range(0, 3));
      id_rs2_addr = 5'($urandom_range(0, 3));
      ex_rd_addr  = 5'($urandom_range(0, 3));
      id_rs1_used = 1'($urandom_range(0, 1));
      id_rs2_used = 1'($urandom_range(0, 1));
      ex_mem_read = ($urandom_range(0, 2) == 0);
      ex_jump     = ($urandom_range(0, 5) == 0);
      mem_req     = ($urandom_range(0, 2) == 0);
      mem_ready   = 1'($urandom_range(0, 1));
      halt_req    = ($urandom_range(0, 39) == 0);
      resume      = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (obs[k] !== model_out(k)) begin n_fail++; $display("FAIL random_outputs dut%0d cyc%0d got=%b want=%b", k, i, obs[k], model_out(k)); end
`ifdef PIPE_CTRL_PERF_EN
        n_tests++;
        if (stall_cnt[k] !== m_stall[k] || flush_cnt[k] !== m_flush[k]) begin
          n_fail++;
          $display("FAIL random_counters dut%0d cyc%0d got stall=%0d flush=%0d want stall=%0d flush=%0d",
                   k, i, stall_cnt[k], flush_cnt[k], m_stall[k], m_flush[k]);
        end
`endif
      end
      tick();
    end
    rst = 1'b1;
    clear_inputs();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_RUN; m_wait[k] = 0; m_err[k] = 0; m_stall[k] = '0; m_flush[k] = '0;
    end
    test_reset();
    test_load_use();
    test_jump_load_use();
    test_mem_wait();
    test_timeout();
    test_halt();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
